cpu_clkgen: RTL and testbench

Run-control and phase generator that sits directly upstream of the CPU core. From a single master clock it produces the core's `clk`, `cntrl_clk` and `alu_clk` phases, the `fetch` address-select strobe, and the core's active-low reset. It also sequences run, single-step and halt, and counts executed instructions. All outputs are flop-driven.

---
 rtl/cpu_clkgen_if.sv | 27 ++
 rtl/cpu_clkgen.sv | 138 +++++++++++++
 tb/tb_cpu_clkgen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_clkgen_if.sv
// Run-control / phase-generator bus between the CPU core side and cpu_clkgen.
// The master drives run-control requests; the slave returns core phases and status.
interface cpu_clkgen_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             step;
    logic             halt;
    logic             cpu_clk;
    logic             cntrl_clk;
    logic             alu_clk;
    logic             fetch;
    logic             cpu_rst_;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, step, halt,
        input  cpu_clk, cntrl_clk, alu_clk, fetch, cpu_rst_, running, halted, instr_count
    );

    modport slave (
        input  start, step, halt,
        output cpu_clk, cntrl_clk, alu_clk, fetch, cpu_rst_, running, halted, instr_count
    );
endinterface

// File: rtl/cpu_clkgen.sv
// Run-control and phase generator for the CPU core: derives core clock phases,
// fetch strobe and core reset from one master clock; sequences run/step/halt.
module cpu_clkgen #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    cpu_clkgen_if.slave bus
);

    localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       sub_q, sub_d;
    logic [2:0]       st_q, st_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic cpu_clk_q, cpu_clk_d;
    logic cntrl_clk_q, cntrl_clk_d;
    logic alu_clk_q, alu_clk_d;
    logic fetch_q, fetch_d;
    logic cpu_rstn_q, cpu_rstn_d;
    logic running_q, running_d;
    logic halted_q, halted_d;

    logic boundary;
    assign boundary = (sub_q == 3'd7) && (st_q == 3'd7);

    // Next-state and phase counters; outputs decode the values the counters take next.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        st_d    = st_q;
        rcnt_d  = rcnt_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_RESET: begin
                sub_d = 3'd0;
                st_d  = 3'd0;
                if (rcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rcnt_d = RC_W'(rcnt_q - 1'b1);
                end
            end
            S_IDLE: begin
                sub_d = 3'd0;
                st_d  = 3'd0;
                if (bus.start) begin
                    state_d = S_RUN;
                end else if (bus.step) begin
                    state_d = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                sub_d = 3'(sub_q + 3'd1);
                if (sub_q == 3'd7) begin
                    st_d = 3'(st_q + 3'd1);
                end
                // halt is only honoured at the instruction boundary and beats step-return
                if (boundary) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (bus.halt) begin
                        state_d = S_HALTED;
                    end else if (state_q == S_STEP) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALTED: begin
                sub_d = 3'd0;
                st_d  = 3'd0;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        running_d   = (state_d == S_RUN) || (state_d == S_STEP);
        halted_d    = (state_d == S_HALTED);
        cpu_rstn_d  = (state_d != S_RESET);
        cntrl_clk_d = running_d && !sub_d[2];
        alu_clk_d   = running_d && (sub_d == 3'd5);
        cpu_clk_d   = running_d && (sub_d == 3'd7);
        fetch_d     = running_d && !st_d[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            sub_q       <= 3'd0;
            st_q        <= 3'd0;
            rcnt_q      <= RC_W'(RST_CYCLES);
            cnt_q       <= '0;
            cpu_clk_q   <= 1'b0;
            cntrl_clk_q <= 1'b0;
            alu_clk_q   <= 1'b0;
            fetch_q     <= 1'b0;
            cpu_rstn_q  <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            st_q        <= st_d;
            rcnt_q      <= rcnt_d;
            cnt_q       <= cnt_d;
            cpu_clk_q   <= cpu_clk_d;
            cntrl_clk_q <= cntrl_clk_d;
            alu_clk_q   <= alu_clk_d;
            fetch_q     <= fetch_d;
            cpu_rstn_q  <= cpu_rstn_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.cpu_clk     = cpu_clk_q;
    assign bus.cntrl_clk   = cntrl_clk_q;
    assign bus.alu_clk     = alu_clk_q;
    assign bus.fetch       = fetch_q;
    assign bus.cpu_rst_    = cpu_rstn_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_clkgen.sv
// Directed bench for cpu_clkgen: expected output vectors are queued when stimulus
// is applied and popped against the DUT one cycle at a time.
module tb_cpu_clkgen;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned RST_CYCLES = 4;
    localparam int unsigned OW         = CNT_W + 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_clkgen_if #(.CNT_W(CNT_W)) bus ();

    cpu_clkgen #(
        .RST_CYCLES(RST_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string           tag;
        logic [OW-1:0]   val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Vector layout: {cpu_clk, cntrl_clk, alu_clk, fetch, cpu_rst_, running, halted, instr_count}
    function automatic logic [OW-1:0] pk(input logic cc, input logic ctl, input logic alu,
                                         input logic fe, input logic rn, input logic run,
                                         input logic hl, input logic [CNT_W-1:0] cnt);
        return {cc, ctl, alu, fe, rn, run, hl, cnt};
    endfunction

    // Cycle k after the accepting edge: sub = k mod 8, st = (k/8) mod 8.
    function automatic logic [OW-1:0] run_exp(input int k, input int base);
        int sub;
        int st;
        sub = k % 8;
        st  = (k / 8) % 8;
        return pk(sub == 7, sub < 4, sub == 5, st < 4, 1'b1, 1'b1, 1'b0, CNT_W'(base + k / 64));
    endfunction

    function automatic logic [OW-1:0] idle_exp(input int cnt);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(cnt));
    endfunction

    function automatic logic [OW-1:0] halt_exp(input int cnt);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, CNT_W'(cnt));
    endfunction

    function automatic logic [OW-1:0] rst_exp();
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(0));
    endfunction

    function automatic logic [OW-1:0] observed();
        return {bus.cpu_clk, bus.cntrl_clk, bus.alu_clk, bus.fetch, bus.cpu_rst_,
                bus.running, bus.halted, bus.instr_count};
    endfunction

    task automatic push(input string tag, input logic [OW-1:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        exp_t          e;
        logic [OW-1:0] obs;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL sb_underflow: observed %h required a queued expectation", observed());
        end else begin
            e   = sb.pop_front();
            obs = observed();
            assert (obs === e.val) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Hold rst for 'hold' edges, release, and follow cpu_rst_ through to IDLE.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        for (int i = 0; i < hold; i++) begin
            push($sformatf("rst_hold%0d", i), rst_exp());
            tick();
            pop_check();
        end
        rst = 1'b0;
        for (int i = 0; i < int'(RST_CYCLES); i++) begin
            push($sformatf("rst_release%0d", i), rst_exp());
            tick();
            pop_check();
        end
        push("rst_done", idle_exp(0));
        tick();
        pop_check();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        bus.halt  = 1'b0;

        do_reset(3);

        // Free run with ignored step/start, then reset mid-instruction at st=5 sub=2
        bus.start = 1'b1;
        for (int k = 0; k <= 234; k++) push($sformatf("run k=%0d", k), run_exp(k, 0));
        for (int k = 0; k <= 234; k++) begin
            tick();
            bus.start = (k == 150);
            bus.step  = (k == 100);
            pop_check();
        end
        bus.start = 1'b0;
        bus.step  = 1'b0;
        do_reset(1);

        // Two single steps from IDLE
        bus.step = 1'b1;
        for (int k = 0; k < 64; k++) push($sformatf("step1 k=%0d", k), run_exp(k, 0));
        for (int i = 0; i < 3; i++) push("step1_idle", idle_exp(1));
        for (int i = 0; i < 67; i++) begin
            tick();
            bus.step = 1'b0;
            pop_check();
        end
        bus.step = 1'b1;
        for (int k = 0; k < 64; k++) push($sformatf("step2 k=%0d", k), run_exp(k, 1));
        for (int i = 0; i < 2; i++) push("step2_idle", idle_exp(2));
        for (int i = 0; i < 66; i++) begin
            tick();
            bus.step = 1'b0;
            pop_check();
        end

        // start and step together selects RUN: no stop at the first boundary
        bus.start = 1'b1;
        bus.step  = 1'b1;
        for (int k = 0; k < 80; k++) push($sformatf("both k=%0d", k), run_exp(k, 2));
        for (int i = 0; i < 80; i++) begin
            tick();
            bus.start = 1'b0;
            bus.step  = 1'b0;
            pop_check();
        end
        do_reset(2);

        // halt raised at st=3 of instruction 2 takes effect only at its boundary
        bus.start = 1'b1;
        for (int k = 0; k < 128; k++) push($sformatf("halt_run k=%0d", k), run_exp(k, 0));
        for (int i = 0; i < 6; i++) push($sformatf("halted%0d", i), halt_exp(2));
        for (int i = 0; i < 134; i++) begin
            tick();
            bus.start = (i == 130);
            bus.step  = (i == 131);
            bus.halt  = (i >= 87) && (i <= 127);
            pop_check();
        end
        bus.start = 1'b0;
        bus.step  = 1'b0;
        bus.halt  = 1'b0;
        do_reset(1);

        n_checks++;
        assert (sb.size() == 0) begin
            n_pass++;
        end else begin
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
